// File: rtl/alu_writeback_if.sv
// Bundles the ALU-to-writeback instruction bus and the register-file write port.
// The master side drives instructions and write acceptance; the slave side is the stage.
interface alu_writeback_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_opcode;
  logic [3:0]           in_cond;
  logic                 in_s;
  logic [RA_W-1:0]      in_rd;
  logic [DATA_W-1:0]    in_result;
  logic [3:0]           in_new_flag;
  logic [3:0]           flag;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [RA_W-1:0]      wb_rd;
  logic [DATA_W-1:0]    wb_data;
  logic [2**RA_W-1:0]   pending_mask;
  logic [15:0]          retire_cnt;
  logic [15:0]          squash_cnt;

  modport master (
    output in_valid, in_opcode, in_cond, in_s, in_rd, in_result, in_new_flag, wb_ready,
    input  in_ready, flag, wb_valid, wb_rd, wb_data, pending_mask, retire_cnt, squash_cnt
  );

  modport slave (
    input  in_valid, in_opcode, in_cond, in_s, in_rd, in_result, in_new_flag, wb_ready,
    output in_ready, flag, wb_valid, wb_rd, wb_data, pending_mask, retire_cnt, squash_cnt
  );
endinterface

// File: rtl/alu_writeback.sv
// Writeback/flag stage after the ALU: condition check, NZCV ownership, 2-entry write queue.
// Define ALU_WB_STATS_EN to build the retire/squash counters; otherwise they read as zero.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
) (
  input logic          clk,
  input logic          reset,
  alu_writeback_if.slave bus
);

  logic [3:0]        r_flag;
  logic [1:0]        r_count;
  logic              r_wptr;
  logic              r_rptr;
  logic [RA_W-1:0]   r_rd   [2];
  logic [DATA_W-1:0] r_data [2];

  logic w_n, w_z, w_c, w_v;
  logic w_pass;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_flag_upd;
  logic [2**RA_W-1:0] w_mask;

  assign {w_n, w_z, w_c, w_v} = r_flag;

  always_comb begin
    w_pass = 1'b0;
    case (bus.in_cond)
      4'h0: w_pass = w_z;
      4'h1: w_pass = !w_z;
      4'h2: w_pass = w_c;
      4'h3: w_pass = !w_c;
      4'h4: w_pass = w_n;
      4'h5: w_pass = !w_n;
      4'h6: w_pass = w_v;
      4'h7: w_pass = !w_v;
      4'h8: w_pass = w_c & !w_z;
      4'h9: w_pass = !w_c | w_z;
      4'hA: w_pass = (w_n == w_v);
      4'hB: w_pass = (w_n != w_v);
      4'hC: w_pass = !w_z & (w_n == w_v);
      4'hD: w_pass = w_z | (w_n != w_v);
      4'hE: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  // Only ALU opcodes below CMP produce a register result.
  assign w_accept   = bus.in_valid & bus.in_ready;
  assign w_push     = w_accept & w_pass & (bus.in_opcode < 4'd11);
  assign w_flag_upd = w_accept & w_pass & (bus.in_s | (bus.in_opcode == 4'd11));
  assign w_pop      = bus.wb_valid & bus.wb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag  <= 4'b0000;
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_flag_upd) r_flag <= bus.in_new_flag;
      if (w_push)     r_wptr <= ~r_wptr;
      if (w_pop)      r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Entry storage needs no reset: every reader is gated by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= bus.in_rd;
      r_data[r_wptr] <= bus.in_result;
    end
  end

  always_comb begin
    w_mask = '0;
    if (r_count != 2'd0) w_mask[r_rd[r_rptr]]  = 1'b1;
    if (r_count == 2'd2) w_mask[r_rd[~r_rptr]] = 1'b1;
  end

  assign bus.in_ready     = (r_count != 2'd2);
  assign bus.flag         = r_flag;
  assign bus.wb_valid     = (r_count != 2'd0);
  assign bus.wb_rd        = bus.wb_valid ? r_rd[r_rptr]   : '0;
  assign bus.wb_data      = bus.wb_valid ? r_data[r_rptr] : '0;
  assign bus.pending_mask = w_mask;

`ifdef ALU_WB_STATS_EN
  logic [15:0] r_retire;
  logic [15:0] r_squash;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire <= 16'd0;
      r_squash <= 16'd0;
    end else if (w_accept) begin
      if (w_pass) r_retire <= r_retire + 16'd1;
      else        r_squash <= r_squash + 16'd1;
    end
  end

  assign bus.retire_cnt = r_retire;
  assign bus.squash_cnt = r_squash;
`else
  assign bus.retire_cnt = 16'd0;
  assign bus.squash_cnt = 16'd0;
`endif

endmodule
